// File: rtl/param_load_counter.sv
// Up/down modulo counter whose value is read back over a shared byte bus and
// which can be reloaded from that bus, LSB beat first, after one turnaround cycle.
//
// state   | meaning
// DRIVE   | counting (when enabled); bus drives the lane_sel byte of count
// RELEASE | single turnaround cycle, bus released, count held
// CAPTURE | bus_in sampled into staging beat beat_q; last beat loads count
module param_load_counter #(
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned BUS_W         = 8,
  parameter int unsigned MODULO        = 0,
  parameter bit          DEFAULT_EN    = 1'b1,
  parameter bit          DEFAULT_DRIVE = 1'b1,
  localparam int         NBEATS        = int'((WIDTH + BUS_W - 1) / BUS_W),
  localparam int         LW            = (NBEATS > 1) ? $clog2(NBEATS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        ctrl_in,
  input  logic [LW-1:0]     lane_sel,
  input  logic [BUS_W-1:0]  bus_in,
  output logic [BUS_W-1:0]  bus_out,
  output logic [BUS_W-1:0]  bus_oe,
  output logic [WIDTH-1:0]  count_out,
  output logic              tc,
  output logic              busy
);

  typedef enum logic [1:0] {DRIVE, RELEASE, CAPTURE} state_t;
  typedef logic [WIDTH-1:0]        cnt_t;
  typedef logic [WIDTH:0]          cnt_ext_t;
  typedef logic [NBEATS*BUS_W-1:0] stage_t;
  typedef logic [LW-1:0]           lane_t;

  // MODULO of 0 selects the natural 2^WIDTH wrap.
  localparam cnt_ext_t MOD_EFF = (MODULO == 0) ? (cnt_ext_t'(1) << WIDTH)
                                               : cnt_ext_t'(MODULO);
  localparam cnt_t     MAX_CNT = cnt_t'(MOD_EFF - cnt_ext_t'(1));

  logic [3:0] ctrl_q;
  logic       load_qq;
  lane_t      lane_q;
  state_t     state_q, state_d;
  lane_t      beat_q, beat_d;
  stage_t     staging_q, staging_d;
  cnt_t       count_q, count_d;
  logic       tc_q, tc_d;

  logic   en, oe, dir, load_pulse;
  stage_t count_pad;

  assign en         = DEFAULT_EN | ctrl_q[0];
  assign oe         = DEFAULT_DRIVE | ctrl_q[2];
  assign dir        = ctrl_q[3];
  assign load_pulse = ctrl_q[1] & ~load_qq;

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    staging_d = staging_q;
    count_d   = count_q;
    tc_d      = 1'b0;
    unique case (state_q)
      DRIVE: begin
        if (load_pulse) state_d = RELEASE;
        if (en) begin
          if (!dir) begin
            if (count_q >= MAX_CNT) begin
              count_d = '0;
              tc_d    = 1'b1;
            end else begin
              count_d = count_q + cnt_t'(1);
            end
          end else begin
            // An out-of-range loaded value snaps to the top without a wrap pulse.
            if (count_q == '0) begin
              count_d = MAX_CNT;
              tc_d    = 1'b1;
            end else if (count_q > MAX_CNT) begin
              count_d = MAX_CNT;
            end else begin
              count_d = count_q - cnt_t'(1);
            end
          end
        end
      end
      RELEASE: begin
        state_d = CAPTURE;
        beat_d  = '0;
      end
      CAPTURE: begin
        for (int b = 0; b < NBEATS; b++) begin
          if (int'(beat_q) == b) staging_d[b*BUS_W +: BUS_W] = bus_in;
        end
        if (int'(beat_q) == NBEATS - 1) begin
          state_d = DRIVE;
          count_d = cnt_t'(staging_d);
        end else begin
          beat_d = beat_q + lane_t'(1);
        end
      end
      default: state_d = DRIVE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q    <= '0;
      load_qq   <= 1'b0;
      lane_q    <= '0;
      state_q   <= DRIVE;
      beat_q    <= '0;
      staging_q <= '0;
      count_q   <= '0;
      tc_q      <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_in;
      load_qq   <= ctrl_q[1];
      lane_q    <= lane_sel;
      state_q   <= state_d;
      beat_q    <= beat_d;
      staging_q <= staging_d;
      count_q   <= count_d;
      tc_q      <= tc_d;
    end
  end

  // Lanes past the top of count read as zero.
  assign count_pad = stage_t'(count_q);

  always_comb begin
    bus_out = '0;
    for (int b = 0; b < NBEATS; b++) begin
      if (int'(lane_q) == b) bus_out = count_pad[b*BUS_W +: BUS_W];
    end
  end

  assign bus_oe    = {BUS_W{(state_q == DRIVE) & oe}};
  assign count_out = count_q;
  assign tc        = tc_q;
  assign busy      = (state_q != DRIVE);

endmodule

// File: tb/tb_param_load_counter.sv
// Bench for param_load_counter: a default instance (2^16 wrap) and a MODULO=10
// instance; expectations are queued per cycle and compared on the falling edge.
module tb_param_load_counter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  a_ctrl, b_ctrl;
  logic        a_lane, b_lane;
  logic [7:0]  a_bus_in, b_bus_in, a_bus_out, b_bus_out, a_bus_oe, b_bus_oe;
  logic [15:0] a_count, b_count;
  logic        a_tc, b_tc, a_busy, b_busy;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] cnt;
    logic        tc;
    logic        busy;
    logic [7:0]  oe;
    logic [7:0]  bus;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  param_load_counter dut_a (
    .clk(clk), .rst_n(rst_n), .ctrl_in(a_ctrl), .lane_sel(a_lane),
    .bus_in(a_bus_in), .bus_out(a_bus_out), .bus_oe(a_bus_oe),
    .count_out(a_count), .tc(a_tc), .busy(a_busy)
  );

  param_load_counter #(.MODULO(10)) dut_b (
    .clk(clk), .rst_n(rst_n), .ctrl_in(b_ctrl), .lane_sel(b_lane),
    .bus_in(b_bus_in), .bus_out(b_bus_out), .bus_oe(b_bus_oe),
    .count_out(b_count), .tc(b_tc), .busy(b_busy)
  );

  function automatic exp_t mk(input logic [15:0] c, input logic t, input logic bz,
                              input logic [7:0] o, input logic [7:0] bs);
    exp_t e;
    e.cnt = c; e.tc = t; e.busy = bz; e.oe = o; e.bus = bs;
    return e;
  endfunction

  // Holds reset for two cycles, then releases it on a falling edge.
  task automatic do_reset(input logic [3:0] ac, input logic [3:0] bc, input logic al);
    rst_n = 1'b0;
    a_ctrl = ac; b_ctrl = bc; a_lane = al; b_lane = 1'b0;
    a_bus_in = 8'h00; b_bus_in = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called on a falling edge; returns five falling edges later with the value loaded.
  task automatic drive_load(input bit to_b, input logic [15:0] v);
    if (to_b) b_ctrl[1] = 1'b1; else a_ctrl[1] = 1'b1;
    repeat (3) @(negedge clk);
    if (to_b) b_bus_in = v[7:0]; else a_bus_in = v[7:0];
    @(negedge clk);
    if (to_b) b_bus_in = v[15:8]; else a_bus_in = v[15:8];
    @(negedge clk);
    if (to_b) b_ctrl[1] = 1'b0; else a_ctrl[1] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_ctrl = 4'h0; b_ctrl = 4'h0; a_lane = 1'b0; b_lane = 1'b0;
    a_bus_in = 8'h00; b_bus_in = 8'h00;
    repeat (3) @(negedge clk);
    n_vec++; if (a_count !== 16'h0000) begin n_err++; $display("FAIL reset_count_a got %h want 0000", a_count); end
    n_vec++; if (a_tc !== 1'b0) begin n_err++; $display("FAIL reset_tc_a got %b want 0", a_tc); end
    n_vec++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy_a got %b want 0", a_busy); end
    n_vec++; if (a_bus_oe !== 8'hFF) begin n_err++; $display("FAIL reset_oe_a got %h want ff", a_bus_oe); end
    n_vec++; if (a_bus_out !== 8'h00) begin n_err++; $display("FAIL reset_bus_a got %h want 00", a_bus_out); end
    n_vec++; if (b_count !== 16'h0000) begin n_err++; $display("FAIL reset_count_b got %h want 0000", b_count); end
  endtask

  task automatic test_count_up();
    exp_t e;
    logic [15:0] kk;
    do_reset(4'h0, 4'h0, 1'b1);
    for (int k = 1; k <= 302; k++) begin
      kk = 16'(k);
      sb_q.push_back(mk(kk, 1'b0, 1'b0, 8'hFF, (k <= 300) ? kk[15:8] : kk[7:0]));
      @(negedge clk);
      e = sb_q.pop_front();
      n_vec++; if (a_count !== e.cnt) begin n_err++; $display("FAIL count_up cnt got %h want %h", a_count, e.cnt); end
      n_vec++; if (a_tc !== e.tc) begin n_err++; $display("FAIL count_up tc got %b want %b", a_tc, e.tc); end
      n_vec++; if (a_bus_oe !== e.oe) begin n_err++; $display("FAIL count_up oe got %h want %h", a_bus_oe, e.oe); end
      n_vec++; if (a_bus_out !== e.bus) begin n_err++; $display("FAIL count_up bus got %h want %h", a_bus_out, e.bus); end
      if (k == 300) a_lane = 1'b0;
    end
  endtask

  task automatic test_modulo_up();
    exp_t e;
    logic [15:0] m;
    do_reset(4'h0, 4'h0, 1'b0);
    for (int k = 1; k <= 25; k++) begin
      m = 16'(k % 10);
      sb_q.push_back(mk(m, (k % 10) == 0, 1'b0, 8'hFF, m[7:0]));
      @(negedge clk);
      e = sb_q.pop_front();
      n_vec++; if (b_count !== e.cnt) begin n_err++; $display("FAIL modulo_up cnt got %h want %h", b_count, e.cnt); end
      n_vec++; if (b_tc !== e.tc) begin n_err++; $display("FAIL modulo_up tc got %b want %b", b_tc, e.tc); end
      n_vec++; if (b_bus_out !== e.bus) begin n_err++; $display("FAIL modulo_up bus got %h want %h", b_bus_out, e.bus); end
    end
  endtask

  task automatic test_modulo_down();
    exp_t e;
    logic [15:0] c [0:5];
    logic        t [0:5];
    c = '{16'd1, 16'd0, 16'd9, 16'd8, 16'd7, 16'd6};
    t = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    // dir is raised during reset, so the first step still counts up.
    do_reset(4'h0, 4'b1000, 1'b0);
    for (int i = 0; i < 6; i++) sb_q.push_back(mk(c[i], t[i], 1'b0, 8'hFF, c[i][7:0]));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      e = sb_q.pop_front();
      n_vec++; if (b_count !== e.cnt) begin n_err++; $display("FAIL modulo_down cnt got %h want %h", b_count, e.cnt); end
      n_vec++; if (b_tc !== e.tc) begin n_err++; $display("FAIL modulo_down tc got %b want %b", b_tc, e.tc); end
    end
  endtask

  task automatic test_load();
    exp_t e;
    logic [15:0] c [0:5];
    logic        b [0:5];
    c = '{16'h0004, 16'h0005, 16'h0005, 16'h0005, 16'hBEEF, 16'hBEF0};
    b = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset(4'h0, 4'h0, 1'b0);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 6; i++) sb_q.push_back(mk(c[i], 1'b0, b[i], b[i] ? 8'h00 : 8'hFF, c[i][7:0]));
    a_ctrl[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      e = sb_q.pop_front();
      n_vec++; if (a_count !== e.cnt) begin n_err++; $display("FAIL load cnt[%0d] got %h want %h", i, a_count, e.cnt); end
      n_vec++; if (a_tc !== e.tc) begin n_err++; $display("FAIL load tc[%0d] got %b want %b", i, a_tc, e.tc); end
      n_vec++; if (a_busy !== e.busy) begin n_err++; $display("FAIL load busy[%0d] got %b want %b", i, a_busy, e.busy); end
      n_vec++; if (a_bus_oe !== e.oe) begin n_err++; $display("FAIL load oe[%0d] got %h want %h", i, a_bus_oe, e.oe); end
      n_vec++; if (a_bus_out !== e.bus) begin n_err++; $display("FAIL load bus[%0d] got %h want %h", i, a_bus_out, e.bus); end
      if (i == 2) a_bus_in = 8'hEF;
      if (i == 3) a_bus_in = 8'hBE;
      if (i == 4) a_ctrl[1] = 1'b0;
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    do_reset(4'h0, 4'h0, 1'b0);
    @(negedge clk);
    drive_load(1'b0, 16'hFFFE);
    sb_q.push_back(mk(16'hFFFE, 1'b0, 1'b0, 8'hFF, 8'hFE));
    sb_q.push_back(mk(16'hFFFF, 1'b0, 1'b0, 8'hFF, 8'hFF));
    sb_q.push_back(mk(16'h0000, 1'b1, 1'b0, 8'hFF, 8'h00));
    sb_q.push_back(mk(16'h0001, 1'b0, 1'b0, 8'hFF, 8'h01));
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      e = sb_q.pop_front();
      n_vec++; if (a_count !== e.cnt) begin n_err++; $display("FAIL wrap cnt[%0d] got %h want %h", i, a_count, e.cnt); end
      n_vec++; if (a_tc !== e.tc) begin n_err++; $display("FAIL wrap tc[%0d] got %b want %b", i, a_tc, e.tc); end
      n_vec++; if (a_bus_out !== e.bus) begin n_err++; $display("FAIL wrap bus[%0d] got %h want %h", i, a_bus_out, e.bus); end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [15:0] c [0:6];
    logic        b [0:6];
    c = '{16'h0004, 16'h0005, 16'h0005, 16'h0005, 16'h1234, 16'h1235, 16'h1236};
    b = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    do_reset(4'h0, 4'h0, 1'b0);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 7; i++) sb_q.push_back(mk(c[i], 1'b0, b[i], b[i] ? 8'h00 : 8'hFF, c[i][7:0]));
    a_ctrl[1] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      e = sb_q.pop_front();
      n_vec++; if (a_count !== e.cnt) begin n_err++; $display("FAIL b2b cnt[%0d] got %h want %h", i, a_count, e.cnt); end
      n_vec++; if (a_busy !== e.busy) begin n_err++; $display("FAIL b2b busy[%0d] got %b want %b", i, a_busy, e.busy); end
      n_vec++; if (a_bus_oe !== e.oe) begin n_err++; $display("FAIL b2b oe[%0d] got %h want %h", i, a_bus_oe, e.oe); end
      // A fresh load edge lands while still capturing and must be dropped.
      if (i == 1) a_ctrl[1] = 1'b0;
      if (i == 2) begin a_ctrl[1] = 1'b1; a_bus_in = 8'h34; end
      if (i == 3) a_bus_in = 8'h12;
      if (i == 4) a_ctrl[1] = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    do_reset(4'h0, 4'h0, 1'b0);
    repeat (3) @(negedge clk);
    a_ctrl[1] = 1'b1;
    repeat (3) @(negedge clk);
    a_bus_in = 8'h55;
    @(negedge clk);
    a_bus_in = 8'hAA;
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (a_count !== 16'h0000) begin n_err++; $display("FAIL rst_mid cnt got %h want 0000", a_count); end
    n_vec++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL rst_mid busy got %b want 0", a_busy); end
    n_vec++; if (a_bus_oe !== 8'hFF) begin n_err++; $display("FAIL rst_mid oe got %h want ff", a_bus_oe); end
    n_vec++; if (a_tc !== 1'b0) begin n_err++; $display("FAIL rst_mid tc got %b want 0", a_tc); end
    a_ctrl[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) sb_q.push_back(mk(16'(k), 1'b0, 1'b0, 8'hFF, 8'(k)));
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      e = sb_q.pop_front();
      n_vec++; if (a_count !== e.cnt) begin n_err++; $display("FAIL rst_mid after cnt got %h want %h", a_count, e.cnt); end
      n_vec++; if (a_busy !== e.busy) begin n_err++; $display("FAIL rst_mid after busy got %b want %b", a_busy, e.busy); end
    end
  endtask

  task automatic test_modulo_load();
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      do_reset(4'h0, (d == 1) ? 4'b1000 : 4'b0000, 1'b0);
      repeat (3) @(negedge clk);
      drive_load(1'b1, 16'h00FF);
      sb_q.push_back(mk(16'h00FF, 1'b0, 1'b0, 8'hFF, 8'hFF));
      if (d == 1) begin
        sb_q.push_back(mk(16'd9, 1'b0, 1'b0, 8'hFF, 8'h09));
        sb_q.push_back(mk(16'd8, 1'b0, 1'b0, 8'hFF, 8'h08));
      end else begin
        sb_q.push_back(mk(16'd0, 1'b1, 1'b0, 8'hFF, 8'h00));
        sb_q.push_back(mk(16'd1, 1'b0, 1'b0, 8'hFF, 8'h01));
      end
      for (int i = 0; i < 3; i++) begin
        if (i > 0) @(negedge clk);
        e = sb_q.pop_front();
        n_vec++; if (b_count !== e.cnt) begin n_err++; $display("FAIL mod_load dir%0d cnt[%0d] got %h want %h", d, i, b_count, e.cnt); end
        n_vec++; if (b_tc !== e.tc) begin n_err++; $display("FAIL mod_load dir%0d tc[%0d] got %b want %b", d, i, b_tc, e.tc); end
        n_vec++; if (b_bus_oe !== e.oe) begin n_err++; $display("FAIL mod_load dir%0d oe[%0d] got %h want %h", d, i, b_bus_oe, e.oe); end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a_ctrl = 4'h0; b_ctrl = 4'h0; a_lane = 1'b0; b_lane = 1'b0;
    a_bus_in = 8'h00; b_bus_in = 8'h00;
    test_reset();
    test_count_up();
    test_modulo_up();
    test_modulo_down();
    test_load();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_modulo_load();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
